// File: rtl/i2c_target_regport_if.sv
// i2c_target_regport_if
// Single-cycle register bus between the I2C target and an on-chip register bank.
//   reg_addr  : register address (the target's current pointer)
//   reg_wdata : write data, qualified by reg_we
//   reg_we    : one-cycle write strobe
//   reg_re    : one-cycle read strobe
//   reg_rdata : read data, valid exactly one clock after reg_re
// Modports: master = I2C target side, slave = register bank side.
interface i2c_target_regport_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_we,
                  output reg_re, input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_we,
                  input reg_re, output reg_rdata);
endinterface

// File: rtl/i2c_target_regport.sv
// i2c_target_regport
// I2C target endpoint: oversamples SCL/SDA on i_clk, detects START/STOP,
// matches a 7-bit device address and turns write/read transfers into
// single-cycle strobes on a register bus, through an 8-bit auto-incrementing
// register pointer (wraps 0xFF -> 0x00).
// Ports:
//   i_clk, i_rst        : system clock, synchronous active-high reset
//   i_scl, i_sda        : raw pad inputs
//   o_sda_oe, o_scl_oe  : open-drain pull-down enables (1 = pull low)
//   regbus              : register bus (master modport)
//   o_busy              : addressed and inside a transfer
//   o_start_det         : one-cycle pulse per START / repeated START
//   o_stop_det          : one-cycle pulse per STOP
// Optional feature macro: I2C_TGT_STRETCH_EN -- hold SCL low on entry to a
// read byte until the read data has been latched. Without it o_scl_oe is 0.
module i2c_target_regport #(
  parameter logic [6:0] DEV_ADDR    = 7'h1D,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_scl,
  input  logic                        i_sda,
  output logic                        o_sda_oe,
  output logic                        o_scl_oe,
  i2c_target_regport_if.master        regbus,
  output logic                        o_busy,
  output logic                        o_start_det,
  output logic                        o_stop_det
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, wdata_q, wdata_d, rx_byte;
  logic       rw_q, rw_d, ack_rose_q, ack_rose_d, sda_oe_q, sda_oe_d;
  logic       we_q, we_d, re_q, re_d, rd_lat_q, rd_lat_d;
  logic       start_det_q, start_det_d, stop_det_q, stop_det_d, rd_entry;
`ifdef I2C_TGT_STRETCH_EN
  logic       scl_oe_q, scl_oe_d;
`endif

  // Flops reset to 1 so a reset looks like an idle bus and cannot fake an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign start_c  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_c   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign rx_byte  = {shift_q[6:0], sda_s};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rw_q        <= 1'b0;
      ack_rose_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rd_lat_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      ack_rose_q  <= ack_rose_d;
      sda_oe_q    <= sda_oe_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rd_lat_q    <= rd_lat_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe_q    <= scl_oe_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    ack_rose_d  = ack_rose_q;
    sda_oe_d    = sda_oe_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    rd_lat_d    = re_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    rd_entry    = 1'b0;
`ifdef I2C_TGT_STRETCH_EN
    scl_oe_d    = scl_oe_q;
`endif

    // Pointer advances the cycle after a write strobe, so the strobe sees the old value.
    if (we_q) ptr_d = ptr_q + 8'd1;

    // rd_lat_q is the cycle in which the bank presents read data.
    if (rd_lat_q) begin
      shift_d = regbus.reg_rdata;
`ifdef I2C_TGT_STRETCH_EN
      if (scl_oe_q) begin
        scl_oe_d = 1'b0;
        sda_oe_d = ~regbus.reg_rdata[7];
      end
`endif
    end

    if (start_c) begin
      state_d     = S_ADDR;
      bit_cnt_d   = 3'd7;
      ack_rose_d  = 1'b0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe_d    = 1'b0;
`endif
    end else if (stop_c) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      stop_det_d = 1'b1;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q != 3'd0) begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end else begin
              ack_rose_d = 1'b0;
              if (state_q == S_ADDR) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
              end else if (state_q == S_REG) begin
                ptr_d   = rx_byte;
                state_d = S_REG_ACK;
              end else begin
                wdata_d = rx_byte;
                state_d = S_WDATA_ACK;
              end
            end
          end
        end
        // ACK phase: pull SDA on the first fall, act on the rise, leave on the next fall.
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_rise) begin
            ack_rose_d = 1'b1;
            if (state_q == S_ADDR_ACK && rw_q) re_d = 1'b1;
            if (state_q == S_WDATA_ACK) we_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rose_q) begin
              sda_oe_d = 1'b1;
            end else begin
              ack_rose_d = 1'b0;
              bit_cnt_d  = 3'd7;
              sda_oe_d   = 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d  = S_RDATA;
                rd_entry = 1'b1;
              end else begin
                state_d = (state_q == S_ADDR_ACK) ? S_REG : S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end else if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_cnt_q != 3'd0) begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end else begin
              ack_rose_d = 1'b0;
              state_d    = S_MACK;
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ack_rose_d = 1'b1;
              ptr_d      = ptr_q + 8'd1;
              re_d       = 1'b1;
            end else begin
              state_d = S_IGNORE;
            end
          end else if (scl_fall) begin
            if (!ack_rose_q) begin
              sda_oe_d = 1'b0;
            end else begin
              ack_rose_d = 1'b0;
              bit_cnt_d  = 3'd7;
              state_d    = S_RDATA;
              rd_entry   = 1'b1;
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase

      // First bit of a read byte goes out on the fall that enters RDATA.
      if (rd_entry) begin
`ifdef I2C_TGT_STRETCH_EN
        if (re_q) begin
          scl_oe_d = 1'b1;
          sda_oe_d = 1'b0;
        end else begin
          sda_oe_d = ~shift_d[7];
        end
`else
        sda_oe_d = ~shift_d[7];
`endif
      end
    end
  end

  assign o_sda_oe         = sda_oe_q;
`ifdef I2C_TGT_STRETCH_EN
  assign o_scl_oe         = scl_oe_q;
`else
  assign o_scl_oe         = 1'b0;
`endif
  assign regbus.reg_addr  = ptr_q;
  assign regbus.reg_wdata = wdata_q;
  assign regbus.reg_we    = we_q;
  assign regbus.reg_re    = re_q;
  assign o_busy           = state_q inside {S_ADDR_ACK, S_REG, S_REG_ACK, S_WDATA,
                                            S_WDATA_ACK, S_RDATA, S_MACK};
  assign o_start_det      = start_det_q;
  assign o_stop_det       = stop_det_q;

endmodule

// File: tb/tb_i2c_target_regport.sv
`timescale 1ns/1ps
module tb_i2c_target_regport;
  localparam int Q = 6;   // quarter SCL period in i_clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_ctl = 1'b1;
  logic sda_ctl = 1'b1;
  logic i_scl, i_sda, sda_oe, scl_oe, busy, sdet, pdet;

  always #10 clk = ~clk;

  i2c_target_regport_if rb ();

  // Open-drain bus: controller and target both only pull low.
  assign i_sda = sda_ctl & ~sda_oe;
  assign i_scl = scl_ctl & ~scl_oe;

  i2c_target_regport dut (
    .i_clk(clk), .i_rst(rst), .i_scl(i_scl), .i_sda(i_sda),
    .o_sda_oe(sda_oe), .o_scl_oe(scl_oe), .regbus(rb.master),
    .o_busy(busy), .o_start_det(sdet), .o_stop_det(pdet)
  );

  // Register bank responder: registered read, one clock latency.
  logic [7:0] bank [256];
  always @(posedge clk) begin
    if (rb.reg_we) bank[rb.reg_addr] <= rb.reg_wdata;
    if (rb.reg_re) rb.reg_rdata <= bank[rb.reg_addr];
  end

  // Monitor: cumulative logs only, the main block reads them with base offsets.
  logic [15:0] obs_w [$];
  logic [7:0]  obs_r [$];
  int n_start = 0, n_stop = 0, oe_cnt = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (rb.reg_we) obs_w.push_back({rb.reg_addr, rb.reg_wdata});
    if (rb.reg_re) obs_r.push_back(rb.reg_addr);
    if (sdet) n_start++;
    if (pdet) n_stop++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  // Reference model: bank contents and pointer from transaction rules.
  logic [7:0]  mdl_bank [256];
  logic [7:0]  mdl_ptr;
  logic [15:0] exp_w [$];
  logic [7:0]  exp_r [$];

  int n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_ctl = 1'b1; tick(Q);
    scl_ctl = 1'b1; tick(2*Q);
    sda_ctl = 1'b0; tick(2*Q);
    scl_ctl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_ctl = 1'b0; tick(Q);
    scl_ctl = 1'b1; tick(2*Q);
    sda_ctl = 1'b1; tick(2*Q);
  endtask

  task automatic bit_out(input logic b);
    sda_ctl = b;    tick(Q);
    scl_ctl = 1'b1; tick(2*Q);
    scl_ctl = 1'b0; tick(Q);
  endtask

  task automatic bit_in(output logic b);
    sda_ctl = 1'b1; tick(Q);
    scl_ctl = 1'b1; tick(Q);
    b = i_sda;      tick(Q);
    scl_ctl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_in(b);
      d = {d[6:0], b};
    end
    bit_out(nack);
  endtask

  task automatic wr_txn(input logic [7:0] p, input logic [7:0] d [4], input int n);
    logic ack;
    int   wb;
    wb = obs_w.size();
    exp_w = {};
    i2c_start();
    write_byte(8'h3A, ack); chk("wr_addr_ack", 32'(ack), 1);
    write_byte(p, ack);     chk("wr_ptr_ack", 32'(ack), 1);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack); chk("wr_data_ack", 32'(ack), 1);
      exp_w.push_back({p + 8'(i), d[i]});
      mdl_bank[p + 8'(i)] = d[i];
    end
    i2c_stop();
    mdl_ptr = p + 8'(n);
    chk("wr_count", obs_w.size() - wb, exp_w.size());
    foreach (exp_w[i])
      if (wb + i < obs_w.size()) chk("wr_strobe", obs_w[wb+i], exp_w[i]);
    chk("wr_ptr_after", rb.reg_addr, mdl_ptr);
  endtask

  task automatic rd_txn(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    int         rbase;
    rbase = obs_r.size();
    exp_r = {};
    i2c_start();
    write_byte(8'h3A, ack); chk("rd_waddr_ack", 32'(ack), 1);
    write_byte(p, ack);     chk("rd_ptr_ack", 32'(ack), 1);
    i2c_start();
    write_byte(8'h3B, ack); chk("rd_raddr_ack", 32'(ack), 1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1));
      chk("rd_byte", d, mdl_bank[p + 8'(i)]);
      exp_r.push_back(p + 8'(i));
    end
    chk("rd_release_after_nack", 32'(sda_oe), 0);
    i2c_stop();
    mdl_ptr = p + 8'(n - 1);
    chk("rd_count", obs_r.size() - rbase, exp_r.size());
    foreach (exp_r[i])
      if (rbase + i < obs_r.size()) chk("rd_strobe_addr", obs_r[rbase+i], exp_r[i]);
    chk("rd_ptr_after", rb.reg_addr, mdl_ptr);
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dd [4];
    logic       ack, b;
    logic [6:0] bad_addr;
    int wb, rbs, st0, sp0, oe0, bz0, n;
    logic [7:0] p;

    tick(5);
    chk("rst_outs_in_reset", {25'd0, sda_oe, scl_oe, busy, rb.reg_we, rb.reg_re, sdet, pdet}, 0);
    chk("rst_addr", rb.reg_addr, 0);
    rst = 1'b0;
    tick(3);
    chk("rst_outs_after", {25'd0, sda_oe, scl_oe, busy, rb.reg_we, rb.reg_re, sdet, pdet}, 0);
    chk("rst_wdata", rb.reg_wdata, 0);

    // Directed write: pointer 0x10, data A5, 3C.
    st0 = n_start; sp0 = n_stop;
    wr_txn(8'h10, '{8'hA5, 8'h3C, 8'h00, 8'h00}, 2);
    chk("wr_start_pulses", n_start - st0, 1);
    chk("wr_stop_pulses", n_stop - sp0, 1);
    chk("idle_busy", 32'(busy), 0);

    // Combined read of 0x55, 0xC3 from 0x06.
    wr_txn(8'h06, '{8'h55, 8'hC3, 8'h00, 8'h00}, 2);
    rd_txn(8'h06, 2);

    // Address mismatch: 0x1E, then a random non-matching address.
    bad_addr = 7'($urandom_range(0, 127));
    if (bad_addr == 7'h1D) bad_addr = 7'h1E;
    wb = obs_w.size(); rbs = obs_r.size(); oe0 = oe_cnt; bz0 = busy_cnt;
    i2c_start();
    write_byte(8'h3C, ack);             chk("mis_ack_1e", 32'(ack), 0);
    write_byte(8'($urandom), ack);      chk("mis_ack_data", 32'(ack), 0);
    i2c_start();
    write_byte({bad_addr, 1'b0}, ack);  chk("mis_ack_rand", 32'(ack), 0);
    i2c_stop();
    chk("mis_sda_oe_cycles", oe_cnt - oe0, 0);
    chk("mis_busy_cycles", busy_cnt - bz0, 0);
    chk("mis_no_we", obs_w.size() - wb, 0);
    chk("mis_no_re", obs_r.size() - rbs, 0);

    // Pointer wrap on write and read.
    wr_txn(8'hFF, '{8'h11, 8'h22, 8'h00, 8'h00}, 2);
    rd_txn(8'hFF, 2);

    // Randomized write-then-readback.
    for (int k = 0; k < 4; k++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
      wr_txn(p, dd, n);
      rd_txn(p, n);
    end

    // Reset while the target drives bit 4 of a read byte low.
    dd[0] = 8'($urandom) & 8'hEF;
    wr_txn(8'h20, dd, 1);
    i2c_start();
    write_byte(8'h3A, ack); chk("rr_waddr_ack", 32'(ack), 1);
    write_byte(8'h20, ack); chk("rr_ptr_ack", 32'(ack), 1);
    i2c_start();
    write_byte(8'h3B, ack); chk("rr_raddr_ack", 32'(ack), 1);
    for (int i = 0; i < 3; i++) bit_in(b);
    sda_ctl = 1'b1; tick(Q);
    scl_ctl = 1'b1; tick(Q);
    chk("rr_drive_bit4", 32'(sda_oe), 1);
    rst = 1'b1; tick(1);
    chk("rr_sda_released", 32'(sda_oe), 0);
    chk("rr_busy_clear", 32'(busy), 0);
    rst = 1'b0; tick(Q);
    scl_ctl = 1'b0; tick(Q);
    i2c_stop();
    chk("rr_ptr_reset", rb.reg_addr, 0);
    for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
    wr_txn(8'($urandom), dd, 3);

    // STOP after three bits of the register byte.
    wb = obs_w.size(); sp0 = n_stop;
    i2c_start();
    write_byte(8'h3A, ack); chk("sg_addr_ack", 32'(ack), 1);
    for (int i = 0; i < 3; i++) bit_out(1'($urandom));
    i2c_stop();
    chk("sg_no_we", obs_w.size() - wb, 0);
    chk("sg_stop_pulse", n_stop - sp0, 1);
    chk("sg_busy", 32'(busy), 0);
    chk("sg_ptr_kept", rb.reg_addr, mdl_ptr);

    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
